time_phase_ctrl: RTL

Programmable sequencer for the three-phase T1/T2/T3 timing generator. Adds the following on a single clock:
- A built-in tick prescaler.
- Per-phase dwell lengths.
- Run, stop and single-step commands.
- A completed-cycle counter.

It sits between the front-panel start/stop/step inputs and the phase outputs, and replaces the fixed one-phase-per-tick sequencing.

---
 rtl/time_phase_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/time_phase_ctrl.sv
// Three-phase T1/T2/T3 sequencer with tick prescaler, per-phase dwell, run/stop/step control
// and a completed-cycle counter. Optional per-run pass limit under `TIME_CYCLE_LIMIT_EN`.
module time_phase_ctrl #(
  parameter int DIV     = 25000000,
  parameter int DIV_W   = 26,
  parameter int DWELL_W = 4
) (
  input  logic               CLK,
  input  logic               Rst,
  input  logic               nSTART,
  input  logic               nSTOP,
  input  logic               nSTEP,
  input  logic [DWELL_W-1:0] DWELL1,
  input  logic [DWELL_W-1:0] DWELL2,
  input  logic [DWELL_W-1:0] DWELL3,
`ifdef TIME_CYCLE_LIMIT_EN
  input  logic [7:0]         CYC_LIMIT,
`endif
  output logic               T1,
  output logic               T2,
  output logic               T3,
  output logic               BUSY,
  output logic               CYC_DONE,
  output logic [7:0]         CYC_CNT
);

  // The phase encoding is itself one-hot, so T1..T3 come straight from flops.
  typedef enum logic [2:0] {
    PH_IDLE = 3'b000,
    PH_T1   = 3'b001,
    PH_T2   = 3'b010,
    PH_T3   = 3'b100
  } phase_e;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } mode_e;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    if (d == '0) dwell_load = DWELL_W'(1);
    else         dwell_load = d;
  endfunction

  phase_e             phase_q, phase_d;
  mode_e              mode_q, mode_d;
  logic               stop_q, stop_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               tick_s;
  logic               phase_end_s;
  logic               start_run_s;
  logic               start_step_s;
  logic               stop_now_s;
  logic               limit_hit_s;
`ifdef TIME_CYCLE_LIMIT_EN
  logic [7:0]         limit_q, limit_d;
  logic [7:0]         pass_q, pass_d;
`endif

  // Next-state, prescaler, dwell and counter logic.
  always_comb begin
    phase_d      = phase_q;
    mode_d       = mode_q;
    stop_d       = stop_q;
    presc_d      = presc_q;
    dwell_d      = dwell_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
`ifdef TIME_CYCLE_LIMIT_EN
    limit_d      = limit_q;
    pass_d       = pass_q;
    limit_hit_s  = (limit_q != 8'd0) && ((pass_q + 8'd1) == limit_q);
`else
    limit_hit_s  = 1'b0;
`endif
    tick_s       = (presc_q == PRESC_LAST);
    phase_end_s  = tick_s && (dwell_q == DWELL_W'(1));
    start_run_s  = !nSTART && nSTOP;
    start_step_s = nSTART && !nSTEP && nSTOP;
    stop_now_s   = stop_q || ((mode_q == MODE_RUN) && !nSTOP);

    if (phase_q == PH_IDLE) begin
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
      dwell_d = dwell_q - DWELL_W'(1);
    end else begin
      presc_d = presc_q + DIV_W'(1);
    end

    // A stop request seen in RUN is held until the pass finishes.
    if ((phase_q != PH_IDLE) && (mode_q == MODE_RUN) && !nSTOP) begin
      stop_d = 1'b1;
    end else begin
      stop_d = stop_d;
    end

    case (phase_q)
      PH_IDLE: begin
        stop_d = 1'b0;
        if (start_run_s) begin
          phase_d = PH_T1;
          mode_d  = MODE_RUN;
          dwell_d = dwell_load(DWELL1);
`ifdef TIME_CYCLE_LIMIT_EN
          limit_d = CYC_LIMIT;
          pass_d  = 8'd0;
`endif
        end else if (start_step_s) begin
          phase_d = PH_T1;
          mode_d  = MODE_STEP;
          dwell_d = dwell_load(DWELL1);
        end else begin
          phase_d = PH_IDLE;
        end
      end
      PH_T1: begin
        if (phase_end_s) begin
          phase_d = PH_T2;
          dwell_d = dwell_load(DWELL2);
        end else begin
          phase_d = PH_T1;
        end
      end
      PH_T2: begin
        if (phase_end_s) begin
          phase_d = PH_T3;
          dwell_d = dwell_load(DWELL3);
        end else begin
          phase_d = PH_T2;
        end
      end
      PH_T3: begin
        if (phase_end_s) begin
          done_d = 1'b1;
          cnt_d  = cnt_q + 8'd1;
`ifdef TIME_CYCLE_LIMIT_EN
          pass_d = pass_q + 8'd1;
`endif
          if ((mode_q == MODE_STEP) || stop_now_s ||
              ((mode_q == MODE_RUN) && limit_hit_s)) begin
            phase_d = PH_IDLE;
            stop_d  = 1'b0;
          end else begin
            phase_d = PH_T1;
            dwell_d = dwell_load(DWELL1);
          end
        end else begin
          phase_d = PH_T3;
        end
      end
      default: begin
        phase_d = PH_IDLE;
        stop_d  = 1'b0;
        presc_d = '0;
      end
    endcase

    busy_d = (phase_d != PH_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      phase_q <= PH_IDLE;
      mode_q  <= MODE_RUN;
      stop_q  <= 1'b0;
      presc_q <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef TIME_CYCLE_LIMIT_EN
      limit_q <= 8'd0;
      pass_q  <= 8'd0;
`endif
    end else begin
      phase_q <= phase_d;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef TIME_CYCLE_LIMIT_EN
      limit_q <= limit_d;
      pass_q  <= pass_d;
`endif
    end
  end

  assign T1       = phase_q[0];
  assign T2       = phase_q[1];
  assign T3       = phase_q[2];
  assign BUSY     = busy_q;
  assign CYC_DONE = done_q;
  assign CYC_CNT  = cnt_q;

endmodule
